// File: rtl/serdes_pkg.sv
// Shared types and the capture-timing helper for the input deserializer.
// Both the top and the bitslip controller import this package.
package serdes_pkg;

  localparam int MAX_DATA_WIDTH = 8;
  localparam int OFFSET_W       = 3;

  typedef logic [OFFSET_W-1:0] offset_t;

  // Result of one capture-timing step: whether to capture on this edge and
  // the value the delay counter takes afterwards.
  typedef struct packed {
    logic    capture;
    offset_t dly;
  } cap_step_t;

  // A strobe either captures immediately (offset 0, or to flush a word that
  // is still waiting on its delay) and reloads the delay with the current
  // offset. Between strobes a non-zero delay counts down and fires at 1.
  function automatic cap_step_t next_capture(input logic    ioce,
                                             input offset_t dly,
                                             input offset_t offset);
    cap_step_t r;
    r.capture = 1'b0;
    r.dly     = dly;
    if (ioce) begin
      r.capture = (offset == '0) || (dly != '0);
      r.dly     = offset;
    end else if (dly != '0) begin
      r.capture = (dly == offset_t'(1));
      r.dly     = dly - offset_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/iserdes_deser_if.sv
// Parallel-side bundle of the deserializer: enables, strobe, serial bit,
// bitslip request and the word/valid/offset results.
interface iserdes_deser_if #(
  parameter int DATA_WIDTH = 4
);

  logic                  CE;
  logic                  IOCE;
  logic                  D;
  logic                  BITSLIP;
  logic [DATA_WIDTH-1:0] Q;
  logic                  VALID;
  logic [2:0]            SLIP_OFFSET;

  modport master (
    output CE, IOCE, D, BITSLIP,
    input  Q, VALID, SLIP_OFFSET
  );

  modport slave (
    input  CE, IOCE, D, BITSLIP,
    output Q, VALID, SLIP_OFFSET
  );

endinterface

// File: rtl/serdes_bitslip_ctl.sv
// Word-boundary control: holds the bitslip offset, the one-slip-per-capture
// holdoff and the delay counter, and flags the edges on which a word is
// captured.
module serdes_bitslip_ctl
  import serdes_pkg::*;
#(
  parameter int    DATA_WIDTH     = 4,
  parameter string BITSLIP_ENABLE = "TRUE"
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    ce,
  input  logic    ioce,
  input  logic    bitslip,
  output logic    capture,
  output offset_t offset
);

  localparam offset_t MAX_OFFSET = offset_t'(DATA_WIDTH - 1);
  localparam logic    SLIP_EN    = (BITSLIP_ENABLE == "TRUE");

  offset_t   dly;
  logic      holdoff;
  logic      slip_accept;
  cap_step_t step;

  // Work out this edge's capture decision and the next delay value.
  always_comb begin
    step = next_capture(ioce, dly, offset);
  end

  assign capture     = ce & step.capture;
  assign slip_accept = SLIP_EN & ce & bitslip & ~holdoff;

  // Offset, holdoff and delay state; a slip accepted on a capture edge keeps
  // the holdoff set so that the next capture is the one that releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly     <= '0;
      offset  <= '0;
      holdoff <= 1'b0;
    end else if (ce) begin
      dly <= step.dly;
      if (slip_accept) begin
        offset  <= (offset == MAX_OFFSET) ? '0 : offset + offset_t'(1);
        holdoff <= 1'b1;
      end else if (step.capture) begin
        holdoff <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iserdes_deser.sv
// Single-clock input deserializer: shifts one bit per IOCLK edge and
// presents a parallel word, earliest bit in the MSB, one cycle after the
// edge that sampled its last bit.
module iserdes_deser
  import serdes_pkg::*;
#(
  parameter int    DATA_WIDTH     = 4,
  parameter string BITSLIP_ENABLE = "TRUE"
) (
  input logic            CLK,
  input logic            RST,
  iserdes_deser_if.slave bus
);

  logic [DATA_WIDTH-2:0] sr;
  logic [DATA_WIDTH-1:0] cw;
  logic [DATA_WIDTH-1:0] q_r;
  logic                  valid_r;
  logic                  capture;
  offset_t               offset;

  assign cw = {sr, bus.D};

  serdes_bitslip_ctl #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BITSLIP_ENABLE (BITSLIP_ENABLE)
  ) u_ctl (
    .clk     (CLK),
    .rst     (RST),
    .ce      (bus.CE),
    .ioce    (bus.IOCE),
    .bitslip (bus.BITSLIP),
    .capture (capture),
    .offset  (offset)
  );

  // Shift register and output word; a clock-enable gap freezes everything
  // and suppresses VALID.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr      <= '0;
      q_r     <= '0;
      valid_r <= 1'b0;
    end else if (bus.CE) begin
      sr      <= cw[DATA_WIDTH-2:0];
      valid_r <= capture;
      if (capture) begin
        q_r <= cw;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.Q           = q_r;
  assign bus.VALID       = valid_r;
  assign bus.SLIP_OFFSET = 3'(offset);

endmodule
